// File: rtl/product_to_bcd.sv
// product_to_bcd: converts a sign/magnitude product into packed BCD for display.
// A double-dabble engine runs one bit per clock. The result is published
// together with a display sign and a leading-zero blanking mask.
//
// Ports:
//   clock      sole clock; all state updates on its rising edge
//   reset_n    asynchronous active-low reset
//   valid      conversion request; sampled only when idle
//   sign       product sign (1 = negative)
//   magnitude  unsigned product magnitude (MAG_W bits)
//   busy       high while a conversion is in flight (CONV or DONE)
//   done       one-cycle pulse when bcd/sign_out/digit_en take new values
//   bcd        packed BCD result; digit 0 (units) in bits [3:0]
//   sign_out   display sign; negative zero is shown as +0
//   digit_en   leading-zero blanking mask; bit i enables digit i
module product_to_bcd #(
  parameter int unsigned MAG_W  = 14,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid,
  input  logic                  sign,
  input  logic [MAG_W-1:0]      magnitude,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned CntW = $clog2(MAG_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q;
  logic [MAG_W-1:0]  shift_q;
  logic [BcdW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              sign_q;

  logic [BcdW-1:0]   acc_adj;
  logic [BcdW-1:0]   acc_shl;
  logic [MAG_W-1:0]  shift_shl;
  logic [DIGITS-1:0] digit_en_d;
  logic              any_nz;

  // Add 3 to any digit >= 5 so the following shift carries into the next decade.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {acc_shl, shift_shl} = {acc_adj, shift_q} << 1;

  // A digit is shown if it or any more significant digit is nonzero; units always shown.
  always_comb begin
    any_nz     = 1'b0;
    digit_en_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz        = any_nz | (|acc_q[4*i +: 4]);
      digit_en_d[i] = any_nz;
    end
    digit_en_d[0] = 1'b1;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      sign_out <= 1'b0;
      digit_en <= DIGITS'(1);
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            shift_q <= magnitude;
            sign_q  <= sign;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StConv;
          end
        end
        StConv: begin
          acc_q   <= acc_shl;
          shift_q <= shift_shl;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntW'(MAG_W - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd      <= acc_q;
          // A zero accumulator means a zero magnitude, which always displays as +0.
          sign_out <= sign_q & (|acc_q);
          digit_en <= digit_en_d;
          done     <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_product_to_bcd.sv
// Bench for product_to_bcd: a transaction-level model predicts every output on
// every cycle, and directed vectors are additionally pinned to literal results.
module tb_product_to_bcd;

  localparam int unsigned MAG_W  = 14;
  localparam int unsigned DIGITS = 5;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                valid;
  logic                sign;
  logic [MAG_W-1:0]    magnitude;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                sign_out;
  logic [DIGITS-1:0]   digit_en;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  product_to_bcd #(.MAG_W(MAG_W), .DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid     (valid),
    .sign      (sign),
    .magnitude (magnitude),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .sign_out  (sign_out),
    .digit_en  (digit_en)
  );

  always #5 clock = ~clock;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned m);
    logic [4*DIGITS-1:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] to_en(input int unsigned m);
    logic [DIGITS-1:0] r;
    int unsigned p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = (m >= p);
      p = p * 10;
    end
    r[0] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge k publishes at edge k+MAG_W+1.
  int                  m_cnt    = 0;
  int unsigned         m_mag    = 0;
  logic                m_sign   = 1'b0;
  logic                exp_busy = 1'b0;
  logic                exp_done = 1'b0;
  logic [4*DIGITS-1:0] exp_bcd  = '0;
  logic                exp_sign = 1'b0;
  logic [DIGITS-1:0]   exp_en   = DIGITS'(1);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt    = 0;
      exp_done = 1'b0;
      exp_bcd  = '0;
      exp_sign = 1'b0;
      exp_en   = DIGITS'(1);
    end else begin
      exp_done = 1'b0;
      if (m_cnt == 0) begin
        if (valid) begin
          m_cnt  = 1;
          m_mag  = int'(magnitude);
          m_sign = sign;
        end
      end else if (m_cnt == MAG_W + 1) begin
        m_cnt    = 0;
        exp_done = 1'b1;
        exp_bcd  = to_bcd(m_mag);
        exp_sign = m_sign && (m_mag != 0);
        exp_en   = to_en(m_mag);
      end else begin
        m_cnt++;
      end
    end
    exp_busy = (m_cnt != 0);
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("bcd", 32'(bcd), 32'(exp_bcd));
      chk("sign_out", 32'(sign_out), 32'(exp_sign));
      chk("digit_en", 32'(digit_en), 32'(exp_en));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic s, input int unsigned m);
    valid     = 1'b1;
    sign      = s;
    magnitude = MAG_W'(m);
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
  endtask

  int unsigned         vec_mag [8] = '{16129, 0, 16383, 9, 1000, 10000, 99, 1};
  logic                vec_sign[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [4*DIGITS-1:0] lit_bcd [8] = '{20'h16129, 20'h00000, 20'h16383, 20'h00009,
                                       20'h01000, 20'h10000, 20'h00099, 20'h00001};
  logic                lit_sign[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [DIGITS-1:0]   lit_en  [8] = '{5'b11111, 5'b00001, 5'b11111, 5'b00001,
                                       5'b01111, 5'b11111, 5'b00011, 5'b00001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    reset_n   = 1'b1;
    valid     = 1'b0;
    sign      = 1'b0;
    magnitude = '0;
    #3 reset_n = 1'b0;
    cmp_en = 1'b1;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_sign_out", 32'(sign_out), 32'd0);
    chk("reset_digit_en", 32'(digit_en), 32'd1);
    reset_n = 1'b1;
    tick();

    // Directed conversions, each pinned to a hand-computed literal.
    for (int v = 0; v < 8; v++) begin
      chk("model_bcd", 32'(to_bcd(vec_mag[v])), 32'(lit_bcd[v]));
      start(vec_sign[v], vec_mag[v]);
      wait_done(n);
      chk("latency", 32'(n), 32'(MAG_W + 1));
      chk("vec_bcd", 32'(bcd), 32'(lit_bcd[v]));
      chk("vec_sign_out", 32'(sign_out), 32'(lit_sign[v]));
      chk("vec_digit_en", 32'(digit_en), 32'(lit_en[v]));
      repeat (2) tick();
    end

    // A request while busy is dropped, not queued.
    start(1'b0, 42);
    repeat (4) tick();
    valid     = 1'b1;
    magnitude = MAG_W'(77);
    tick();
    valid = 1'b0;
    wait_done(n);
    chk("busy_ignore_latency", 32'(n), 32'(MAG_W + 1 - 5));
    chk("busy_ignore_bcd", 32'(bcd), 32'h00042);
    count_dones(MAG_W + 4, n);
    chk("busy_ignore_no_second_done", 32'(n), 32'd0);

    // Reset mid-conversion aborts it and clears outputs at once.
    start(1'b0, 255);
    repeat (6) tick();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_digit_en", 32'(digit_en), 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    count_dones(MAG_W + 4, n);
    chk("abort_no_done", 32'(n), 32'd0);
    start(1'b0, 300);
    wait_done(n);
    chk("after_abort_latency", 32'(n), 32'(MAG_W + 1));
    chk("after_abort_bcd", 32'(bcd), 32'h00300);

    // valid held high: back-to-back conversions MAG_W+2 cycles apart.
    valid     = 1'b1;
    sign      = 1'b0;
    magnitude = MAG_W'(12);
    tick();
    magnitude = MAG_W'(34);
    wait_done(n);
    chk("held_first_latency", 32'(n), 32'(MAG_W + 1));
    chk("held_first_bcd", 32'(bcd), 32'h00012);
    tick();
    valid = 1'b0;
    wait_done(n2);
    chk("held_spacing", 32'(n2 + 1), 32'(MAG_W + 2));
    chk("held_second_bcd", 32'(bcd), 32'h00034);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_to_bcd.md
PRODUCT_TO_BCD -- requirements
Module: product_to_bcd

Interface
REQ-001 Parameter MAG_W, default 14: width of the unsigned magnitude input.
REQ-002 Parameter DIGITS, default 5: number of BCD digits produced; SHALL satisfy 10^DIGITS > 2^MAG_W - 1.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 valid  input  1  request to convert sign/magnitude; sampled only in IDLE.
REQ-006 sign  input  1  product sign (1 = negative).
REQ-007 magnitude  input  MAG_W  unsigned product magnitude.
REQ-008 busy  output  1  high while a conversion is in progress (CONV or DONE).
REQ-009 done  output  1  one-cycle pulse marking new bcd/sign_out/digit_en values.
REQ-010 bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-011 sign_out  output  1  display sign registered with bcd.
REQ-012 digit_en  output  DIGITS  leading-zero blanking mask; bit i enables digit i.

Function
REQ-013 FSM states: IDLE, CONV, DONE; reset state IDLE.
REQ-014 IDLE with valid=1 at edge k: capture magnitude into the shift register, capture sign, clear the BCD accumulator, clear the iteration counter, and enter CONV.
REQ-015 IDLE with valid=0: hold state and all outputs.
REQ-016 CONV, each edge: add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one bit; increment the counter.
REQ-017 CONV SHALL perform exactly MAG_W iterations (edges k+1..k+MAG_W); the edge completing iteration MAG_W enters DONE.
REQ-018 DONE, at edge k+MAG_W+1: load bcd, sign_out, digit_en; assert done for exactly that following cycle; return to IDLE.
REQ-019 Latency: done high in the cycle after edge k+MAG_W+1 (cycle 16 after acceptance for MAG_W=14); throughput one conversion per MAG_W+2 cycles.
REQ-020 bcd, sign_out, digit_en SHALL hold their last values from one done until the next done; the intermediate accumulator is never visible on bcd.
REQ-021 sign_out = captured sign AND (magnitude != 0); negative zero SHALL display as +0.
REQ-022 digit_en bit i = 1 iff some digit j >= i is nonzero; bit 0 SHALL always be 1.
REQ-023 valid while busy=1 SHALL be ignored and SHALL NOT queue; magnitude/sign changes after acceptance SHALL NOT affect the result.
REQ-024 valid may be held high: a new conversion starts at the first edge in IDLE after done, with the then-current inputs.
REQ-025 Any magnitude 0..2^MAG_W-1 SHALL convert exactly; no saturation or overflow flag.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, busy=0, done=0, bcd=0, sign_out=0, digit_en=1 (bit 0 only), counter and shift/accumulator registers = 0.
REQ-027 Reset during CONV or DONE SHALL abort the conversion with no done pulse; outputs take the reset values.
REQ-028 After reset_n deasserts, the first rising edge with valid=1 SHALL be accepted normally.

Verification
REQ-029 magnitude=16129, sign=1, valid pulse -> 16 cycles later done=1, bcd=20'h16129, sign_out=1, digit_en=5'b11111.
REQ-030 magnitude=0, sign=1 -> bcd=20'h00000, sign_out=0, digit_en=5'b00001.
REQ-031 magnitude=16383, sign=0 -> bcd=20'h16383, sign_out=0; magnitude=9 -> bcd=20'h00009, digit_en=5'b00001; magnitude=1000 -> bcd=20'h01000, digit_en=5'b01111.
REQ-032 Accept 42, pulse valid with 77 at cycle 5 of CONV -> single done with bcd=20'h00042; no second done follows.
REQ-033 Accept 255, assert reset_n low at cycle 7 of CONV -> busy=0 immediately, no done, bcd=0; a new conversion of 300 then yields bcd=20'h00300.
REQ-034 valid held high with inputs 12 then 34 -> done pulses exactly MAG_W+2 cycles apart with bcd=20'h00012 then 20'h00034.
